// File: rtl/gberet_hvgen.sv
// Video timing generator: 6 MHz pixel enable, 9-bit H/V raster counters,
// registered blank/sync/frame outputs with per-frame adjustable sync position.
// Free-running; outputs are aligned with PH/PV on every cycle (zero relative latency).
module gberet_hvgen #(
  parameter int H_TOTAL  = 384,
  parameter int H_VIS    = 256,
  parameter int HS_START = 304,
  parameter int HS_LEN   = 32,
  parameter int V_TOTAL  = 264,
  parameter int V_VIS0   = 16,
  parameter int V_VIS1   = 239,
  parameter int VS_START = 248,
  parameter int VS_LEN   = 8
) (
  input  logic       clk48M,
  input  logic       reset,
  input  logic [3:0] hoffs,
  input  logic [3:0] voffs,
  output logic       PCE,
  output logic [8:0] PH,
  output logic [8:0] PV,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       FRAME
);

  localparam logic [8:0] HT_M1  = 9'(H_TOTAL - 1);
  localparam logic [8:0] VT_M1  = 9'(V_TOTAL - 1);
  localparam logic [8:0] HV_L   = 9'(H_VIS);
  localparam logic [8:0] V0_L   = 9'(V_VIS0);
  localparam logic [8:0] V1_L   = 9'(V_VIS1);
  localparam logic [8:0] HS_L   = 9'(HS_START);
  localparam logic [8:0] HSW_L  = 9'(HS_LEN);
  localparam logic [8:0] VS_L   = 9'(VS_START);
  localparam logic [8:0] VSW_L  = 9'(VS_LEN);

  logic [2:0] div_q, div_d;
  logic       pce_q, pce_d;
  logic [8:0] ph_q, ph_d;
  logic [8:0] pv_q, pv_d;
  logic       hblank_q, hblank_d;
  logic       vblank_q, vblank_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       frame_q, frame_d;
  logic [3:0] hoffs_l_q, hoffs_l_d;
  logic [3:0] voffs_l_q, voffs_l_d;
  logic [8:0] hs0, vs0;

  // Next-state: divider always runs; raster and derived outputs move only on div==7
  always_comb begin
    div_d     = div_q + 3'd1;
    pce_d     = (div_q == 3'd7);
    ph_d      = ph_q;
    pv_d      = pv_q;
    hblank_d  = hblank_q;
    vblank_d  = vblank_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    frame_d   = 1'b0;
    hoffs_l_d = hoffs_l_q;
    voffs_l_d = voffs_l_q;
    hs0       = '0;
    vs0       = '0;
    if (div_q == 3'd7) begin
      if (ph_q == HT_M1) begin
        ph_d = '0;
        pv_d = (pv_q == VT_M1) ? 9'd0 : pv_q + 9'd1;
      end else begin
        ph_d = ph_q + 9'd1;
      end
      // Offsets only change at frame start so a frame never sees a jumping sync
      if ((ph_d == 9'd0) && (pv_d == 9'd0)) begin
        frame_d   = 1'b1;
        hoffs_l_d = hoffs;
        voffs_l_d = voffs;
      end
      hs0      = HS_L + {{5{hoffs_l_d[3]}}, hoffs_l_d};
      vs0      = VS_L + {{5{voffs_l_d[3]}}, voffs_l_d};
      hblank_d = (ph_d >= HV_L);
      vblank_d = (pv_d < V0_L) || (pv_d > V1_L);
      hsync_d  = (ph_d >= hs0) && (ph_d < hs0 + HSW_L);
      vsync_d  = (pv_d >= vs0) && (pv_d < vs0 + VSW_L);
    end
  end

  // State registers with synchronous reset to the top-left, blanked raster
  always_ff @(posedge clk48M) begin
    if (reset) begin
      div_q     <= '0;
      pce_q     <= 1'b0;
      ph_q      <= '0;
      pv_q      <= '0;
      hblank_q  <= 1'b0;
      vblank_q  <= 1'b1;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      frame_q   <= 1'b0;
      hoffs_l_q <= '0;
      voffs_l_q <= '0;
    end else begin
      div_q     <= div_d;
      pce_q     <= pce_d;
      ph_q      <= ph_d;
      pv_q      <= pv_d;
      hblank_q  <= hblank_d;
      vblank_q  <= vblank_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      frame_q   <= frame_d;
      hoffs_l_q <= hoffs_l_d;
      voffs_l_q <= voffs_l_d;
    end
  end

  assign PCE    = pce_q;
  assign PH     = ph_q;
  assign PV     = pv_q;
  assign HBLANK = hblank_q;
  assign VBLANK = vblank_q;
  assign HSYNC  = hsync_q;
  assign VSYNC  = vsync_q;
  assign FRAME  = frame_q;

endmodule
